// File: rtl/cardinal_dmem_arbiter_if.sv
// Node-side request/return bundle for the Cardinal dmem arbiter.
// Vectors are big-endian: node i owns bit i, addr[8i +: 8] and wdata[64i +: 64].
interface cardinal_dmem_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [0:NUM_REQ-1]    req;
  logic [0:NUM_REQ-1]    wr;
  logic [0:8*NUM_REQ-1]  addr;
  logic [0:64*NUM_REQ-1] wdata;
  logic [0:NUM_REQ-1]    gnt;
  logic [0:NUM_REQ-1]    rvalid;
  logic [0:63]           rdata;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/cardinal_dmem_arbiter.sv
// Round-robin share of one single-port 256x64 dmem among four CMP nodes,
// with tagged read return and saturating per-node grant counters.
module cardinal_dmem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  cardinal_dmem_arbiter_if.slave   node,
  output logic                     mem_en,
  output logic                     mem_wr_en,
  output logic [0:7]               mem_addr,
  output logic [0:63]              mem_din,
  input  logic [0:63]              mem_dout,
  input  logic                     clr_stats,
  output logic [0:NUM_REQ*CNT_W-1] grant_cnt
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]              ptr, win, idx;
  logic                       found, hit, rd_now;
  logic [RD_LAT-1:0]          vld_pipe;
  logic [RD_LAT-1:0][PW-1:0]  id_pipe;

  // Search from ptr upward; the 2-bit add wraps modulo 4 for free.
  always_comb begin
    found    = 1'b0;
    win      = ptr;
    idx      = ptr;
    node.gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + PW'(k);
      if (!found && node.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    hit = found & reset;
    if (hit) node.gnt[win] = 1'b1;
  end

  assign rd_now     = hit & ~node.wr[win];
  assign node.rdata = mem_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      mem_en    <= hit;
      mem_wr_en <= hit & node.wr[win];
      if (hit) begin
        ptr      <= win + 1'b1;
        mem_addr <= node.addr[8*win +: 8];
        mem_din  <= node.wdata[64*win +: 64];
      end
    end
  end

  // Read tag rides alongside mem_en, then RD_LAT-1 more stages, then rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      id_pipe     <= '0;
      node.rvalid <= '0;
    end else begin
      vld_pipe[0] <= rd_now;
      id_pipe[0]  <= win;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
      node.rvalid <= '0;
      if (vld_pipe[RD_LAT-1]) node.rvalid[id_pipe[RD_LAT-1]] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] c;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        c <= '0;
      else if (clr_stats)                c <= '0;
      else if (node.gnt[i] && c != '1)   c <= c + 1'b1;
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = c;
  end
endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// Scoreboarded bench for cardinal_dmem_arbiter: directed vectors, read returns
// checked by a monitor against expectations queued at grant time.
module tb_cardinal_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n, clr, s_clr;
  always #5 clk = ~clk;

  cardinal_dmem_arbiter_if #(.NUM_REQ(4)) nif ();
  cardinal_dmem_arbiter_if #(.NUM_REQ(4)) sif ();

  logic        mem_en, mem_wr_en;
  logic [0:7]  mem_addr;
  logic [0:63] mem_din, mem_dout;
  logic [0:63] gcnt;
  logic        s_en, s_wen;
  logic [0:7]  s_addr;
  logic [0:63] s_din;
  logic [0:15] s_cnt;

  cardinal_dmem_arbiter dut (
    .clk(clk), .reset(rst_n), .node(nif),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .clr_stats(clr), .grant_cnt(gcnt)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  cardinal_dmem_arbiter #(.CNT_W(4)) sdut (
    .clk(clk), .reset(rst_n), .node(sif),
    .mem_en(s_en), .mem_wr_en(s_wen), .mem_addr(s_addr),
    .mem_din(s_din), .mem_dout(64'h0),
    .clr_stats(s_clr), .grant_cnt(s_cnt)
  );

  // dmem model: one-cycle read latency, write lands on the command edge.
  logic [63:0] dm [256];
  bit          loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      dm[5]  <= 64'hA5A5_0000_0000_0001;
      loaded <= 1'b1;
    end
    if (mem_en && mem_wr_en) dm[mem_addr] <= mem_din;
    else if (mem_en)         mem_dout     <= dm[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  oh;
    logic [63:0] d;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] A5 = 64'hA5A5_0000_0000_0001;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_node(input int i, input logic r, input logic w,
                          input logic [7:0] a, input logic [63:0] d);
    nif.req[i]           = r;
    nif.wr[i]            = w;
    nif.addr[8*i +: 8]   = a;
    nif.wdata[64*i +: 64] = d;
  endtask

  // Called at a negedge: check gnt, and queue the read return if it is a read.
  task automatic gnt_chk(input string nm, input logic [3:0] exp, input logic rd,
                         input logic [63:0] d);
    chk(nm, nif.gnt, exp);
    if (rd) sb.push_back('{exp, d, cyc + 2});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (nif.rvalid != 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rv_unexpected actual rvalid=%b required none", nif.rvalid);
        end else begin
          e = sb.pop_front();
          chk("rv_id", nif.rvalid, e.oh);
          chk("rv_data", nif.rdata, e.d);
          chk("rv_latency", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    fork monitor(); join_none
    rst_n = 1'b1; clr = 1'b0; s_clr = 1'b0;
    nif.req = '0; nif.wr = '0; nif.addr = '0; nif.wdata = '0;
    sif.req = '0; sif.wr = '0; sif.addr = '0; sif.wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", nif.gnt, 0);
    chk("rst_rvalid", nif.rvalid, 0);
    chk("rst_mem_en", {mem_en, mem_wr_en}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_cnt", gcnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single read by node2, then ptr=3 shows as node3 beating node0.
    set_node(2, 1, 0, 8'h05, 0);
    @(negedge clk); gnt_chk("t1_gnt", 4'b0010, 1, A5);
    tick(); set_node(2, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_rd", mem_wr_en, 0);
    chk("t1_mem_addr", mem_addr, 8'h05);
    tick();
    set_node(0, 1, 1, 8'h20, 64'h1111);
    set_node(3, 1, 1, 8'h21, 64'h3333);
    @(negedge clk); gnt_chk("t1_ptr3", 4'b0001, 0, 0);
    tick(); set_node(3, 0, 0, 0, 0);
    @(negedge clk); gnt_chk("t1_wrap0", 4'b1000, 0, 0);
    tick(); set_node(0, 0, 0, 0, 0);

    // Write then read-back of the same address.
    set_node(0, 1, 1, 8'h10, DB);
    @(negedge clk); gnt_chk("t2_wr_gnt", 4'b1000, 0, 0);
    tick(); set_node(0, 1, 0, 8'h10, 0);
    @(negedge clk);
    chk("t2_wr_en", mem_wr_en, 1);
    chk("t2_wr_addr", mem_addr, 8'h10);
    chk("t2_wr_din", mem_din, DB);
    gnt_chk("t2_rd_gnt", 4'b1000, 1, DB);
    tick(); set_node(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_wr_once", mem_wr_en, 0);
    chk("t2_rd_en", mem_en, 1);
    tick();

    // Clear stats together with a node3 grant (clear wins); ptr goes to 0.
    set_node(3, 1, 1, 8'h22, 0); clr = 1'b1;
    @(negedge clk); gnt_chk("t3_pre_gnt", 4'b0001, 0, 0);
    tick(); clr = 1'b0; set_node(3, 0, 0, 0, 0);
    @(negedge clk); chk("t3_clr_wins", gcnt, 0);
    tick();

    // All four requesting reads for 8 cycles.
    set_node(0, 1, 0, 8'h10, 0);
    set_node(1, 1, 0, 8'h05, 0);
    set_node(2, 1, 0, 8'h05, 0);
    set_node(3, 1, 0, 8'h10, 0);
    for (int k = 0; k < 8; k++) begin
      e = 4'b1000 >> (k % 4);
      @(negedge clk); gnt_chk("t3_rr_gnt", e, 1, (k % 4 == 0 || k % 4 == 3) ? DB : A5);
      tick();
    end
    nif.req = '0;
    repeat (3) tick();
    chk("t3_cnt", gcnt, {4{16'd2}});

    // ptr=3 with nodes 1 and 2 requesting.
    set_node(2, 1, 1, 8'h30, 64'h2);
    @(negedge clk); gnt_chk("t4_set_ptr3", 4'b0010, 0, 0);
    tick(); set_node(1, 1, 1, 8'h31, 64'h1);
    @(negedge clk); gnt_chk("t4_skip_a", 4'b0100, 0, 0); tick();
    @(negedge clk); gnt_chk("t4_skip_b", 4'b0010, 0, 0); tick();
    @(negedge clk); gnt_chk("t4_skip_c", 4'b0100, 0, 0); tick();
    @(negedge clk); gnt_chk("t4_skip_d", 4'b0010, 0, 0); tick();
    nif.req = '0;

    // Saturation on the 4-bit counter instance.
    sif.req = 4'b1000; sif.wr = 4'b1000;
    repeat (14) tick();
    chk("t5_cnt_e", s_cnt[0:3], 4'hE);
    repeat (3) tick();
    chk("t5_cnt_sat", s_cnt[0:3], 4'hF);
    repeat (2) tick();
    chk("t5_cnt_hold", s_cnt, 16'hF000);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0; sif.req = '0;
    chk("t5_clr_wins", s_cnt[0:3], 4'h0);
    tick();
    chk("t5_after_clr", s_cnt, 16'h0000);

    // Reset in the cycle a node1 read is on mem_en.
    set_node(1, 1, 0, 8'h05, 0);
    @(negedge clk); gnt_chk("t6_gnt", 4'b0100, 0, 0);
    tick(); set_node(1, 0, 0, 0, 0);
    chk("t6_pre_en", mem_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", {mem_en, mem_wr_en}, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_din", mem_din, 0);
    chk("t6_rst_rvalid", nif.rvalid, 0);
    chk("t6_rst_cnt", gcnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    set_node(0, 1, 0, 8'h10, 0);
    set_node(3, 1, 1, 8'h41, 0);
    @(negedge clk); gnt_chk("t6_ptr0", 4'b1000, 1, DB);
    tick(); set_node(0, 0, 0, 0, 0);
    @(negedge clk); gnt_chk("t6_next", 4'b0001, 0, 0);
    tick(); set_node(3, 0, 0, 0, 0);
    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cardinal_dmem_arbiter.md
Name: cardinal_dmem_arbiter

Overview:
- Shares one single-ported 256x64 data memory between the four Cardinal CMP nodes. Each node has a req/gnt request port. The memory-side signals match the dmem pin set: memEn, memWrEn, 8-bit address, 64-bit data in and out.
- Arbitration is round-robin. Memory commands are registered, and read returns are tagged so each one is steered back to the node that issued it.
- Saturating per-node grant counters are provided for bandwidth profiling.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed at 4; the pointer is 2 bits.
- RD_LAT, 1, cycles from the registered mem_en (read) output to valid mem_dout.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low. reset=0 clears all state immediately.
- req  in  [0:3]  request per node; bit i = node i.
- wr  in  [0:3]  1=write, 0=read. Qualified by req.
- addr  in  [0:31]  node i address at bits [8i:8i+7].
- wdata  in  [0:255]  node i write data at bits [64i:64i+63].
- gnt  out  [0:3]  one-hot, combinational; request accepted this cycle.
- rvalid  out  [0:3]  one-hot, registered; read data for node i on rdata.
- rdata  out  [0:63]  read data, driven straight from mem_dout.
- mem_en  out  1  registered memEn to dmem.
- mem_wr_en  out  1  registered memWrEn to dmem.
- mem_addr  out  [0:7]  registered address to dmem.
- mem_din  out  [0:63]  registered write data to dmem.
- mem_dout  in  [0:63]  read data from dmem.
- clr_stats  in  1  synchronous clear of the grant counters.
- grant_cnt  out  [0:63]  4 x CNT_W saturating counters; node i at bits [16i:16i+15].

Behaviour:
- Reset values: all outputs 0, pointer ptr=0, read-tag pipeline empty, counters 0. Reset asserted mid-operation discards in-flight reads; no rvalid is produced for them after reset is released.
- Arbitration (combinational, every cycle):
  - Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - The first i with req[i]=1 wins, and gnt[i]=1. At most one gnt bit is set per cycle.
  - If req=0, then gnt=0.
- Requester rule: req, wr, addr and wdata must stay stable until the cycle in which gnt is sampled high. A requester may keep req high to issue back-to-back commands.
- On a posedge where gnt[w] is set:
  - mem_en=1, mem_wr_en=wr[w], mem_addr=addr[w], mem_din=wdata[w]. These hold for exactly one cycle.
  - ptr <= (w+1) mod 4. With no grant, ptr is held.
- With no grant: mem_en=0 and mem_wr_en=0. mem_addr and mem_din hold their previous values.
- Throughput: one command per cycle. A node that is continuously requesting waits at most 3 cycles for a grant.
- Read return:
  - A read granted in cycle N drives mem_en in cycle N+1.
  - The tag {valid, id} moves through an RD_LAT-deep shift register.
  - rvalid[id]=1 in cycle N+1+RD_LAT; rdata=mem_dout in that same cycle.
  - Writes produce no rvalid.
  - Reads return in grant order; no reordering.
- Ordering: a write granted in cycle N followed by a read of the same address granted in N+1 returns the new data, because dmem writes at the posedge where the read is not yet sampled.
- Counters: grant_cnt[i] increments on every grant to node i and saturates at 2^CNT_W-1; it does not wrap. When clr_stats and a grant occur in the same cycle, clr_stats wins and the counter becomes 0.
- Invalid inputs are ignored: wr, addr and wdata for nodes with req=0.

Test Plan:
- Single read:
  - Stimulus: node2 req=1, wr=0, addr=8'h05; DM[5]=64'hA5A5_0000_0000_0001.
  - Required: gnt=4'b0010 in cycle 0; mem_en=1 and mem_addr=5 in cycle 1; rvalid=4'b0010 and rdata=64'hA5A5_0000_0000_0001 in cycle 2; ptr=3.
- Write then read-back:
  - Stimulus: node0 writes 64'hDEAD_BEEF_0000_0000 to addr 8'h10, then reads addr 8'h10 in the next cycle.
  - Required: mem_wr_en=1 for one cycle; the read returns 64'hDEAD_BEEF_0000_0000 on rvalid[0].
- All-request round-robin:
  - Stimulus: req=4'b1111 held for 8 cycles, all reads, starting from ptr=0.
  - Required: grant order is nodes 0,1,2,3,0,1,2,3; each rvalid follows its grant by 2 cycles; grant_cnt = 2 for every node.
- Wrap-around and skip:
  - Stimulus: ptr=3, req=4'b0110 (nodes 1 and 2).
  - Required: node1 granted, then node2, then node1; node3 and node0 are never granted.
- Counter saturation and clear:
  - Stimulus: force grant_cnt[0]=16'hFFFE, then 3 grants to node0.
  - Required: grant_cnt[0] reads 16'hFFFF and holds. Then clr_stats together with a node0 grant: grant_cnt[0]=0.
- Reset mid-read:
  - Stimulus: node1 read granted, reset=0 asserted in the cycle mem_en=1, released 2 cycles later.
  - Required: all outputs 0 immediately on reset assertion; no rvalid ever appears; the next request from node0 is granted with ptr=0.
